// File: rtl/hazard_pkg.sv
// hazard_pkg: types and helpers shared by the hazard path
// (stall/flush sequencer and forwarding unit).
package hazard_pkg;

   localparam logic [4:0] REG_ZERO = 5'h00;

   // Wide enough for any memory timeout limit up to 255.
   localparam int TMO_W = 8;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      MD_WAIT  = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      C_NONE  = 3'd0,
      C_MEM   = 3'd1,
      C_MD    = 3'd2,
      C_REDIR = 3'd3,
      C_LDUSE = 3'd4
   } cause_e;

   function automatic logic load_use(
      input logic       ld,
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2
   );
      return ld && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: hazard inputs from the pipeline and the
// stall/flush/status outputs of the sequencer.
interface pipeline_stall_ctrl_if #(
   parameter int CNT_W = 32
);

   logic             LoadE;
   logic [4:0]       RD_E;
   logic [4:0]       Rs1_D;
   logic [4:0]       Rs2_D;
   logic             PCSrcE;
   logic             MemReqM;
   logic             MemReadyM;
   logic             MdStartE;
   logic             MdDoneE;
   logic             StallF;
   logic             StallD;
   logic             StallE;
   logic             StallM;
   logic             FlushD;
   logic             FlushE;
   logic             FlushM;
   logic             FlushW;
   logic             MemTimeout;
   logic [CNT_W-1:0] StallCnt;

   // Pipeline side: reports hazard sources, obeys stalls/flushes.
   modport master (
      output LoadE, RD_E, Rs1_D, Rs2_D, PCSrcE,
      output MemReqM, MemReadyM, MdStartE, MdDoneE,
      input  StallF, StallD, StallE, StallM,
      input  FlushD, FlushE, FlushM, FlushW,
      input  MemTimeout, StallCnt
   );

   // Sequencer side.
   modport slave (
      input  LoadE, RD_E, Rs1_D, Rs2_D, PCSrcE,
      input  MemReqM, MemReadyM, MdStartE, MdDoneE,
      output StallF, StallD, StallE, StallM,
      output FlushD, FlushE, FlushM, FlushW,
      output MemTimeout, StallCnt
   );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// sat_counter: up-counter with synchronous clear that holds at
// all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Clear wins over increment; increment stops at all-ones.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush sequencer for the 5-stage pipeline,
// covering hazards that forwarding cannot resolve.
module pipeline_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_stall_ctrl_if.slave hz
);

   state_e           state;
   state_e           state_n;
   cause_e           cause;
   cause_e           late_cause;
   logic             mem_hit;
   logic             md_hit;
   logic             lu_hit;
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_clr;
   logic             tmo_inc;
   logic             tmo_set;

   assign mem_hit = hz.MemReqM & ~hz.MemReadyM;
   assign md_hit  = hz.MdStartE & ~hz.MdDoneE;
   assign lu_hit  = load_use(hz.LoadE, hz.RD_E, hz.Rs1_D, hz.Rs2_D);

   // Redirect beats load-use: the Decode instruction is discarded anyway.
   assign late_cause = hz.PCSrcE ? C_REDIR :
                       lu_hit    ? C_LDUSE : C_NONE;

   // State register; reset abandons any outstanding wait.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         state <= state_n;
      end
   end

   // Next state and the winning cause for this cycle.
   always_comb begin
      state_n = state;
      cause   = C_NONE;
      unique case (state)
         RUN: begin
            if (mem_hit) begin
               cause   = C_MEM;
               state_n = MEM_WAIT;
            end else if (md_hit) begin
               cause   = C_MD;
               state_n = MD_WAIT;
            end else begin
               cause = late_cause;
            end
         end
         MEM_WAIT: begin
            if (!hz.MemReadyM) begin
               cause = C_MEM;
            end else if (md_hit) begin
               cause   = C_MD;
               state_n = MD_WAIT;
            end else begin
               cause   = late_cause;
               state_n = RUN;
            end
         end
         MD_WAIT: begin
            if (!hz.MdDoneE) begin
               cause = C_MD;
            end else begin
               cause   = late_cause;
               state_n = RUN;
            end
         end
         default: state_n = RUN;
      endcase
   end

   // Per-stage stall/flush decode; reset drains every stage to bubbles.
   always_comb begin
      hz.StallF = 1'b0;
      hz.StallD = 1'b0;
      hz.StallE = 1'b0;
      hz.StallM = 1'b0;
      hz.FlushD = 1'b0;
      hz.FlushE = 1'b0;
      hz.FlushM = 1'b0;
      hz.FlushW = 1'b0;
      if (!rst) begin
         hz.FlushD = 1'b1;
         hz.FlushE = 1'b1;
         hz.FlushM = 1'b1;
         hz.FlushW = 1'b1;
      end else begin
         unique case (cause)
            C_MEM: begin
               hz.StallF = 1'b1;
               hz.StallD = 1'b1;
               hz.StallE = 1'b1;
               hz.StallM = 1'b1;
               hz.FlushW = 1'b1;
            end
            C_MD: begin
               hz.StallF = 1'b1;
               hz.StallD = 1'b1;
               hz.StallE = 1'b1;
               hz.FlushM = 1'b1;
            end
            C_REDIR: begin
               hz.FlushD = 1'b1;
               hz.FlushE = 1'b1;
            end
            C_LDUSE: begin
               hz.StallF = 1'b1;
               hz.StallD = 1'b1;
               hz.FlushE = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Count restarts when a wait begins and advances per MEM_WAIT cycle.
   assign tmo_clr = (state == RUN) & mem_hit;
   assign tmo_inc = (state == MEM_WAIT);
   assign tmo_set = (state == MEM_WAIT) & ~hz.MemReadyM &
                    (tmo_cnt >= TMO_W'(MEM_TIMEOUT - 1));

   sat_counter #(.W(TMO_W)) u_tmo_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (tmo_clr),
      .inc   (tmo_inc),
      .count (tmo_cnt)
   );

   // Sticky timeout flag; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hz.MemTimeout <= 1'b0;
      end else if (tmo_set) begin
         hz.MemTimeout <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (1'b0),
      .inc   (hz.StallF),
      .count (hz.StallCnt)
   );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed table, timeout/reset sequence and
// random stimulus checked against a cycle-level reference model.
module tb_pipeline_stall_ctrl;

   localparam int     MEM_TIMEOUT = 8;
   localparam int     CNT_W       = 32;
   localparam longint CNT_MAX     = (64'd1 << CNT_W) - 1;

   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
   localparam logic [7:0] O_NONE = 8'b0000_0000;
   localparam logic [7:0] O_RST  = 8'b0000_1111;
   localparam logic [7:0] O_LU   = 8'b1100_0100;
   localparam logic [7:0] O_BR   = 8'b0000_1100;
   localparam logic [7:0] O_MEM  = 8'b1111_0001;
   localparam logic [7:0] O_MD   = 8'b1110_0010;

   typedef struct {
      logic       rst;
      logic       ld;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       br;
      logic       req;
      logic       rdy;
      logic       mds;
      logic       mdd;
      int         exp;
      int         tmo;
      longint     cnt;
   } vec_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_miss;

   bit     m_mem;
   bit     m_md;
   bit     m_tmo;
   int     m_wcnt;
   longint m_scnt;

   vec_t tbl[$];

   pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) hz ();

   pipeline_stall_ctrl #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   // Free-running clock, 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic r, input logic ld, input int rd, input int rs1,
      input int rs2, input logic br, input logic req, input logic rdy,
      input logic mds, input logic mdd, input int exp, input int tmo,
      input longint cnt
   );
      vec_t v;
      v.rst = r;   v.ld = ld;
      v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
      v.br = br;   v.req = req; v.rdy = rdy;
      v.mds = mds; v.mdd = mdd;
      v.exp = exp; v.tmo = tmo; v.cnt = cnt;
      return v;
   endfunction

   function automatic logic [7:0] dut_out();
      return {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
              hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW};
   endfunction

   // Reference: which wait (if any) is open decides what may stall.
   function automatic logic [7:0] model_out(input vec_t v);
      bit mem_stall;
      bit md_stall;
      if (!v.rst) return O_RST;
      if (m_mem) mem_stall = !v.rdy;
      else       mem_stall = !m_md && v.req && !v.rdy;
      if (mem_stall) return O_MEM;
      if (m_md) md_stall = !v.mdd;
      else      md_stall = v.mds && !v.mdd;
      if (md_stall) return O_MD;
      if (v.br) return O_BR;
      if (v.ld && v.rd != 0 && (v.rd == v.rs1 || v.rd == v.rs2))
         return O_LU;
      return O_NONE;
   endfunction

   task automatic model_step(input vec_t v, input logic [7:0] o);
      if (!v.rst) begin
         m_mem = 0; m_md = 0; m_tmo = 0; m_wcnt = 0; m_scnt = 0;
      end else begin
         if (m_mem && !v.rdy) begin
            if (m_wcnt < 255) m_wcnt++;
            if (m_wcnt >= MEM_TIMEOUT) m_tmo = 1;
         end else if (!m_mem && o == O_MEM) begin
            m_wcnt = 0;
         end
         if (o[7] && m_scnt < CNT_MAX) m_scnt++;
         m_mem = (o == O_MEM);
         m_md  = (o == O_MD);
      end
   endtask

   task automatic check(input string name, input longint got,
                        input longint want);
      if (got != want) begin
         n_miss++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      logic [7:0] mo;
      rst          = v.rst;
      hz.LoadE     = v.ld;
      hz.RD_E      = v.rd;
      hz.Rs1_D     = v.rs1;
      hz.Rs2_D     = v.rs2;
      hz.PCSrcE    = v.br;
      hz.MemReqM   = v.req;
      hz.MemReadyM = v.rdy;
      hz.MdStartE  = v.mds;
      hz.MdDoneE   = v.mdd;
      @(negedge clk);
      n_vec++;
      mo = model_out(v);
      check({tag, " out/model"}, longint'(dut_out()), longint'(mo));
      if (v.exp >= 0)
         check({tag, " out/table"}, longint'(dut_out()), longint'(v.exp));
      check({tag, " tmo/model"}, longint'(hz.MemTimeout), longint'(m_tmo));
      if (v.tmo >= 0)
         check({tag, " tmo/table"}, longint'(hz.MemTimeout), longint'(v.tmo));
      check({tag, " cnt/model"}, longint'(hz.StallCnt), m_scnt);
      if (v.cnt >= 0)
         check({tag, " cnt/table"}, longint'(hz.StallCnt), v.cnt);
      @(posedge clk);
      model_step(v, mo);
      #1;
   endtask

   // Stimulus: directed table, timeout/reset sequence, then random.
   initial begin
      vec_t v;
      n_vec = 0; n_miss = 0;
      m_mem = 0; m_md = 0; m_tmo = 0; m_wcnt = 0; m_scnt = 0;
      rst = 1'b0;
      hz.LoadE = 0; hz.RD_E = 0; hz.Rs1_D = 0; hz.Rs2_D = 0;
      hz.PCSrcE = 0; hz.MemReqM = 0; hz.MemReadyM = 0;
      hz.MdStartE = 0; hz.MdDoneE = 0;
      repeat (2) @(posedge clk);
      #1;

      //           r ld rd s1 s2 br rq ry ms md exp     t cnt
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,O_RST, 0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,O_NONE,0,0));
      tbl.push_back(mk(1,1,5,0,5,0,0,0,0,0,O_LU,  0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,O_NONE,0,1));
      tbl.push_back(mk(1,1,0,0,0,0,0,0,0,0,O_NONE,0,1));
      tbl.push_back(mk(1,1,7,7,2,0,0,0,0,0,O_LU,  0,1));
      tbl.push_back(mk(1,1,5,1,5,1,0,0,0,0,O_BR,  0,2));
      tbl.push_back(mk(1,0,0,0,0,1,1,0,0,0,O_MEM, 0,2));
      tbl.push_back(mk(1,0,0,0,0,1,1,0,0,0,O_MEM, 0,3));
      tbl.push_back(mk(1,0,0,0,0,1,1,0,0,0,O_MEM, 0,4));
      tbl.push_back(mk(1,0,0,0,0,1,1,1,0,0,O_BR,  0,5));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,O_NONE,0,5));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,O_MD,  0,5));
      tbl.push_back(mk(1,0,0,0,0,0,1,0,1,0,O_MD,  0,6));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,O_MD,  0,7));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,O_MD,  0,8));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,1,1,O_NONE,0,9));
      tbl.push_back(mk(1,0,0,0,0,0,1,1,0,0,O_NONE,0,9));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,1,1,O_NONE,0,9));
      tbl.push_back(mk(1,0,0,0,0,0,1,0,1,0,O_MEM, 0,9));
      tbl.push_back(mk(1,0,0,0,0,0,1,0,1,0,O_MEM, 0,10));
      tbl.push_back(mk(1,0,0,0,0,0,1,1,1,0,O_MD,  0,11));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,O_MD,  0,12));
      tbl.push_back(mk(1,1,3,3,0,0,0,0,1,1,O_LU,  0,13));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,O_NONE,0,14));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,O_MD,  0,14));
      tbl.push_back(mk(1,0,0,0,0,1,0,0,1,1,O_BR,  0,15));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,O_NONE,0,15));
      tbl.push_back(mk(1,1,4,4,0,0,1,0,0,0,O_MEM, 0,15));
      tbl.push_back(mk(1,1,4,4,0,0,1,0,0,0,O_MEM, 0,16));
      tbl.push_back(mk(1,1,4,4,0,0,1,1,0,0,O_LU,  0,17));
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,O_NONE,0,18));

      foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

      // Timeout: entry cycle, then MEM_WAIT cycles 1..9.
      for (int j = 0; j <= 9; j++)
         apply(mk(1,0,0,0,0,0,1,0,0,0,O_MEM,(j == 9) ? 1 : 0,-1),
               $sformatf("tmo%0d", j));
      apply(mk(1,0,0,0,0,0,1,1,0,0,O_NONE,1,-1), "tmo_rdy");
      apply(mk(1,0,0,0,0,0,0,0,0,0,O_NONE,1,-1), "tmo_sticky");
      apply(mk(1,0,0,0,0,0,1,0,0,0,O_MEM, 1,-1), "rw0");
      apply(mk(1,0,0,0,0,0,1,0,0,0,O_MEM, 1,-1), "rw1");
      apply(mk(0,0,0,0,0,0,1,0,0,0,O_RST, 1,-1), "rw_rst");
      apply(mk(1,0,0,0,0,1,0,0,0,0,O_BR,  0,0),  "rw_run");
      apply(mk(1,0,0,0,0,0,0,0,0,0,O_NONE,0,0),  "rw_idle");

      for (int i = 0; i < 1500; i++) begin
         v.rst = ($urandom_range(63) != 0);
         v.ld  = 1'($urandom_range(1));
         v.rd  = 5'($urandom_range(7));
         v.rs1 = 5'($urandom_range(7));
         v.rs2 = 5'($urandom_range(7));
         v.br  = ($urandom_range(3) == 0);
         v.req = ($urandom_range(2) == 0);
         v.rdy = ($urandom_range(3) != 0);
         v.mds = ($urandom_range(3) == 0);
         v.mdd = 1'($urandom_range(1));
         v.exp = -1; v.tmo = -1; v.cnt = -1;
         apply(v, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Stall/flush sequencer for the 5-stage RV32 pipeline; sits beside the forwarding unit in the hazard path.
- Resolves hazards that forwarding cannot cover:
  - load-use;
  - taken branch/jump redirect;
  - multi-cycle data-memory access;
  - multi-cycle mul/div in Execute.
- Drives per-stage stall/flush enables and keeps a timeout flag and a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 255: max MEM_WAIT cycles before MemTimeout sets; range 1..255.
- CNT_W, 32: width of StallCnt.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-low.
- LoadE  input  1  instruction in Execute is a load.
- RD_E  input  5  destination register of Execute instruction.
- Rs1_D, Rs2_D  input  5 each  source registers of Decode instruction.
- PCSrcE  input  1  branch/jump taken, resolved in Execute.
- MemReqM  input  1  Memory-stage instruction is accessing data memory.
- MemReadyM  input  1  data memory completes the access this cycle.
- MdStartE  input  1  Execute holds a multi-cycle mul/div op.
- MdDoneE  input  1  mul/div result valid this cycle.
- StallF, StallD, StallE, StallM  output  1 each  hold the pipeline register feeding that stage.
- FlushD, FlushE, FlushM, FlushW  output  1 each  load a bubble into that pipeline register.
- MemTimeout  output  1  sticky: memory access exceeded MEM_TIMEOUT.
- StallCnt  output  CNT_W  saturating count of cycles with StallF=1.

Behaviour:
- Stall/flush outputs are combinational from state and inputs. State, timeout counter, MemTimeout and StallCnt are registered.
- Reset (rst=0 at posedge):
  - state<=RUN; timeout counter<=0; MemTimeout<=0; StallCnt<=0.
  - While rst=0, all Stall*=0 and all Flush*=1, so the pipeline drains to bubbles.
  - Reset mid-wait abandons the wait unconditionally.
- States:
  - RUN: normal flow.
  - MEM_WAIT: memory access outstanding.
  - MD_WAIT: mul/div busy.
- Cause evaluation in RUN, in priority order:
  1. Memory: MemReqM=1 and MemReadyM=0.
     - StallF, StallD, StallE, StallM=1; FlushW=1.
     - Next state MEM_WAIT.
  2. Mul/div: MdStartE=1 and MdDoneE=0.
     - StallF, StallD, StallE=1; FlushM=1.
     - Next state MD_WAIT.
  3. Redirect: PCSrcE=1.
     - FlushD=1, FlushE=1; no stall.
     - Overrides load-use because the Decode instruction is discarded.
  4. Load-use: LoadE=1, RD_E!=0, and (RD_E==Rs1_D or RD_E==Rs2_D).
     - StallF=1, StallD=1, FlushE=1.
     - Single cycle; stays in RUN.
  5. None of the above: all outputs 0.
  - Single-cycle memory (MemReqM and MemReadyM both 1) or single-cycle mul/div (MdStartE and MdDoneE both 1) causes no stall.
- MEM_WAIT:
  - While MemReadyM=0: cause-1 outputs held; redirect and load-use suppressed.
  - Cycle with MemReadyM=1: stalls release that same cycle, state<=RUN, and causes 2-4 are evaluated in that cycle. A pending PCSrcE or MdStartE was held stable by the stall, so it takes effect here.
- MD_WAIT:
  - While MdDoneE=0: cause-2 outputs held; redirect and load-use suppressed.
  - A memory stall cannot arise here because M receives only bubbles after the first wait cycle.
  - Cycle with MdDoneE=1: release, state<=RUN, causes 3-4 are evaluated.
- Simultaneous memory and mul/div causes: MEM_WAIT first; after MemReadyM, MdStartE is re-evaluated and enters MD_WAIT if still busy.
- Timeout:
  - Counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle; it saturates and never wraps.
  - When the count reaches MEM_TIMEOUT with MemReadyM=0, MemTimeout<=1.
  - MemTimeout clears only on reset. The FSM does not recover; it stays in MEM_WAIT until MemReadyM arrives.
- StallCnt increments by 1 each cycle StallF=1 and saturates at all-ones.

Decomposition:
- Shared package hazard_pkg:
  - state enum {RUN, MEM_WAIT, MD_WAIT}, 2 bits;
  - REG_ZERO = 5'h00;
  - the load-use compare as a function, also usable by the forwarding logic.
- Natural sub-module: sat_counter (parameterised width, inc, clear, sync active-low rst), used for both the timeout counter and StallCnt.

Test Plan:
- Load-use: LoadE=1, RD_E=5, Rs2_D=5 for one cycle -> StallF=StallD=FlushE=1 that cycle only; StallCnt=1. Same stimulus with RD_E=0 -> all outputs 0.
- Redirect over load-use: PCSrcE=1 with a load-use match -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF..StallM=1 and FlushW=1 for exactly 3 cycles, release on the ready cycle; a PCSrcE=1 held throughout produces FlushD=FlushE only on the ready cycle.
- Mul/div: MdStartE=1 with MdDoneE low for 4 cycles -> StallF..StallE=1, FlushM=1 for 4 cycles; StallCnt=4; MemReqM pulsed during the wait is ignored.
- Timeout: MEM_TIMEOUT=8, MemReadyM held 0 -> MemTimeout rises after the 8th wait cycle, stays 1 after MemReadyM; assert rst=0 mid-wait -> next cycle state RUN, MemTimeout=0, StallCnt=0, all Flush*=1 during reset.
- Simultaneous causes: MemReqM not ready and MdStartE=1 together -> MEM_WAIT outputs first, then MD_WAIT outputs after MemReadyM until MdDoneE.
